sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's basic FIFO, for buffering between pipeline stages and peripherals (UART, MMIO, and similar). It uses all `FIFO_DEPTH` entries, presents the head word first-word-fall-through, and adds an occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush. Sticky overflow/underflow error flags are optional at compile time.

---
 rtl/sync_fifo.sv | 132 +++++++++++++
 tb/tb_sync_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO that uses all
//            FIFO_DEPTH entries. It provides an occupancy count,
//            programmable almost-full/almost-empty flags and a synchronous
//            flush.
// Options  : Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky
//            overflow/underflow flags. When it is not defined, both outputs
//            are tied low and no flag registers are built.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 32,
  parameter int ADDR_WIDTH      = $clog2(FIFO_DEPTH),
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);

  // Storage has no reset. Only the pointers and count decide which entries are valid.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop, mem_we;

  // Status flags decode from the registered count only. This keeps
  // wr_en and rd_en off every output path.
  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= ALMOST_FULL_TH);
  assign almost_empty = (int'(count_q) <= ALMOST_EMPTY_TH);
  assign count        = count_q;
  assign dout         = empty ? '0 : mem_q[rp_q];

  // Qualify requests, then compute the next pointer and count state. Flush overrides both.
  always_comb begin
    push    = wr_en & ~full;
    pop     = rd_en & ~empty;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    mem_we  = 1'b0;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      mem_we = push & reset;
      if (push) wp_d = wp_q + C_PTR_ONE;
      if (pop)  rp_d = rp_q + C_PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Register the pointers and count. Active-low reset is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Write the accepted push data into storage at the write pointer.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wp_q] <= din;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags. Each one sets on a request made against a full or empty FIFO.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Register the error flags. Reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Self-checking bench for sync_fifo (DEPTH=8, AF_TH=6, AE_TH=2).
//            A queue holds the words expected in FIFO order. Error-flag
//            expectations follow SYNC_FIFO_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] dout;
  logic [AW:0]   count;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] sb[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  sync_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle and update the scoreboard. Outputs can be sampled 1 time unit after the edge.
  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd,
                       input bit fl, input bit rs);
    bit was_full, was_empty;
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    wr_en = wr; din = d; rd_en = rd; flush = fl; reset = ~rs;
    if (rs || fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ERR_EN && wr && was_full)  m_ovf = 1'b1;
      if (ERR_EN && rd && was_empty) m_unf = 1'b1;
      if (rd && !was_empty) void'(sb.pop_front());
      if (wr && !was_full)  sb.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (empty !== 1'b1)        begin n_bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    n_cmp++; if (count !== 4'd0)        begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (dout !== 8'h00)        begin n_bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    n_cmp++; if (full !== 1'b0)         begin n_bad++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (almost_full !== 1'b0)  begin n_bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b%b exp=00", overflow, underflow); end
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= AF)) begin n_bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= AF)); end
      n_cmp++; if (almost_empty !== (i + 1 <= AE)) begin n_bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i + 1 <= AE)); end
      n_cmp++; if (full !== (i + 1 == DEPTH)) begin n_bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i + 1 == DEPTH)); end
      n_cmp++; if (dout !== 8'h11) begin n_bad++; $display("FAIL fill_head[%0d] got=%h exp=11", i, dout); end
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
    n_cmp++; if (overflow !== ERR_EN) begin n_bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ERR_EN); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL ovf_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, sb[0]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if ({empty, dout} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL drain_empty got=%b/%h exp=1/00", empty, dout); end
    n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL drain_ovf_sticky got=%b exp=%b", overflow, m_ovf); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (underflow !== ERR_EN) begin n_bad++; $display("FAIL unf_flag got=%b exp=%b", underflow, ERR_EN); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL unf_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL wrap_dout[%0d] got=%h exp=%h", i, dout, sb[0]); end
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL wrap_count[%0d] got=%0d exp=3", i, count); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dout !== sb[0]) begin n_bad++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, dout, sb[0]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL simfull_count got=%0d exp=7", count); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      n_cmp++; if (dout !== sb[0] || dout === 8'hAA) begin n_bad++; $display("FAIL simfull_dout[%0d] got=%h exp=%h", i, dout, sb[0]); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL simfull_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({count, empty, dout} !== {4'd1, 1'b0, 8'h55}) begin n_bad++; $display("FAIL simempty got=%0d/%b/%h exp=1/0/55", count, empty, dout); end
    n_cmp++; if (underflow !== m_unf) begin n_bad++; $display("FAIL simempty_unf got=%b exp=%b", underflow, m_unf); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({count, empty, dout} !== {4'd0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL flush_state got=%0d/%b/%h exp=0/1/00", count, empty, dout); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL flush_err got=%b%b exp=00", overflow, underflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_discard got=%0d exp=0", count); end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h73, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({count, empty} !== {4'd0, 1'b1}) begin n_bad++; $display("FAIL rst_mid got=%0d/%b exp=0/1", count, empty); end
    cycle(1'b1, 8'h74, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({count, dout} !== {4'd1, 8'h74}) begin n_bad++; $display("FAIL rst_first_push got=%0d/%h exp=1/74", count, dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_flush();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
